// File: rtl/z80_bus_responder_pkg.sv
// Shared types and helpers for the Z80 bus responder: FSM states, bus cycle kinds,
// the value seen on a floating data bus, and cycle-kind classification functions.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_INTA = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        K_MEM_RD = 3'd0,
        K_MEM_WR = 3'd1,
        K_IO_RD  = 3'd2,
        K_IO_WR  = 3'd3,
        K_INTA   = 3'd4
    } cyc_kind_e;

    localparam logic [7:0] BUS_FLOAT = 8'hFF;

    function automatic logic kind_is_read(input cyc_kind_e kind);
        return (kind == K_MEM_RD) || (kind == K_IO_RD);
    endfunction

    function automatic logic kind_is_write(input cyc_kind_e kind);
        return (kind == K_MEM_WR) || (kind == K_IO_WR);
    endfunction

    function automatic logic kind_is_io(input cyc_kind_e kind);
        return (kind == K_IO_RD) || (kind == K_IO_WR);
    endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// Signal bundle between the Z80 core/backend side (master) and the bus responder (slave).
interface z80_bus_responder_if;

    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [7:0]  cpu_di;
    logic        cpu_di_en;
    logic        wait_n;
    logic        int_n;
    logic        bk_req;
    logic        bk_we;
    logic        bk_io;
    logic [15:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        bk_ack;
    logic [7:0]  bk_rdata;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic        bus_err;

    modport master (
        output A, cpu_dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
               bk_ack, bk_rdata, irq_req, irq_vector,
        input  cpu_di, cpu_di_en, wait_n, int_n,
               bk_req, bk_we, bk_io, bk_addr, bk_wdata, bus_err
    );

    modport slave (
        input  A, cpu_dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
               bk_ack, bk_rdata, irq_req, irq_vector,
        output cpu_di, cpu_di_en, wait_n, int_n,
               bk_req, bk_we, bk_io, bk_addr, bk_wdata, bus_err
    );

endinterface

// File: rtl/z80_bus_responder_irq_ctrl.sv
// Interrupt source for the responder: irq_req rising-edge detect, pending flag,
// registered int_n and the IM2 vector mux (floating bus when nothing is pending).
module z80_irq_ctrl
    import z80_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_req,
    input  logic [7:0] irq_vector,
    input  logic       clear,
    output logic       int_n,
    output logic       pending,
    output logic [7:0] vector
);

    logic irq_d_r;
    logic pending_r;
    logic int_n_r;
    logic rise_s;
    logic pending_nx_s;

    // Edge detect; a new edge outranks a clear arriving in the same cycle
    always_comb begin
        rise_s       = irq_req && !irq_d_r;
        pending_nx_s = rise_s || (pending_r && !clear);
    end

    // Edge history, pending flag and int_n registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d_r   <= 1'b0;
            pending_r <= 1'b0;
            int_n_r   <= 1'b1;
        end else begin
            irq_d_r   <= irq_req;
            pending_r <= pending_nx_s;
            int_n_r   <= !pending_nx_s;
        end
    end

    assign int_n   = int_n_r;
    assign pending = pending_r;
    assign vector  = pending_r ? irq_vector : BUS_FLOAT;

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: windowed memory/I/O decode to a req/ack backend, wait_n stretching,
// IM2 interrupt acknowledge. Define Z80_BUS_RESPONDER_TIMEOUT_EN for the backend ack deadline.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'h0000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_BASE  = 8'h10,
    parameter logic [7:0]  IO_MASK  = 8'hF0,
    parameter int          TIMEOUT  = 255
) (
    input logic                clk,
    input logic                reset,
    z80_bus_responder_if.slave bus
);

    state_e    state_r;
    state_e    state_nx_s;
    cyc_kind_e kind_s;
    cyc_kind_e kind_r;

    logic strobe_s;
    logic mem_cyc_s;
    logic io_cyc_s;
    logic inta_s;
    logic bus_idle_s;
    logic start_s;
    logic to_hit_s;

    logic wait_n_s;
    logic start_evt_s;
    logic ack_evt_s;
    logic timeout_evt_s;
    logic inta_enter_s;
    logic release_evt_s;
    logic inta_clr_s;

    logic        bk_req_r;
    logic        bk_we_r;
    logic        bk_io_r;
    logic [15:0] bk_addr_r;
    logic [7:0]  bk_wdata_r;
    logic [7:0]  cpu_di_r;
    logic        cpu_di_en_r;
    logic        inta_had_r;

    logic        pending_s;
    logic [7:0]  vec_s;
    logic        int_n_s;

    // Strobe decode; refresh cycles are excluded through rfsh_n
    always_comb begin
        strobe_s   = !bus.rd_n || !bus.wr_n;
        mem_cyc_s  = !bus.mreq_n && bus.rfsh_n && strobe_s;
        io_cyc_s   = !bus.iorq_n && bus.m1_n && strobe_s;
        inta_s     = !bus.m1_n && !bus.iorq_n;
        bus_idle_s = bus.rd_n && bus.wr_n && bus.mreq_n && bus.iorq_n;
        start_s    = (mem_cyc_s && ((bus.A & MEM_MASK) == MEM_BASE)) ||
                     (io_cyc_s && ((bus.A[7:0] & IO_MASK) == IO_BASE));
        if (io_cyc_s) begin
            kind_s = bus.wr_n ? K_IO_RD : K_IO_WR;
        end else if (mem_cyc_s) begin
            kind_s = bus.wr_n ? K_MEM_RD : K_MEM_WR;
        end else begin
            kind_s = K_INTA;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state, wait_n and the datapath events
    always_comb begin
        state_nx_s    = state_r;
        wait_n_s      = 1'b1;
        start_evt_s   = 1'b0;
        ack_evt_s     = 1'b0;
        timeout_evt_s = 1'b0;
        inta_enter_s  = 1'b0;
        release_evt_s = 1'b0;
        inta_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    wait_n_s    = 1'b0;
                    start_evt_s = 1'b1;
                    state_nx_s  = ST_REQ;
                end else if (inta_s) begin
                    inta_enter_s = 1'b1;
                    state_nx_s   = ST_INTA;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                wait_n_s = 1'b0;
                if (bus.bk_ack) begin
                    ack_evt_s  = 1'b1;
                    state_nx_s = ST_HOLD;
                end else if (to_hit_s) begin
                    timeout_evt_s = 1'b1;
                    state_nx_s    = ST_HOLD;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (bus_idle_s) begin
                    release_evt_s = 1'b1;
                    state_nx_s    = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_INTA: begin
                if (bus.iorq_n) begin
                    release_evt_s = 1'b1;
                    inta_clr_s    = inta_had_r;
                    state_nx_s    = ST_IDLE;
                end else begin
                    state_nx_s = ST_INTA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Backend request fields and CPU read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bk_req_r    <= 1'b0;
            bk_we_r     <= 1'b0;
            bk_io_r     <= 1'b0;
            bk_addr_r   <= 16'h0000;
            bk_wdata_r  <= 8'h00;
            kind_r      <= K_MEM_RD;
            cpu_di_r    <= BUS_FLOAT;
            cpu_di_en_r <= 1'b0;
            inta_had_r  <= 1'b0;
        end else if (start_evt_s) begin
            bk_req_r   <= 1'b1;
            bk_we_r    <= kind_is_write(kind_s);
            bk_io_r    <= kind_is_io(kind_s);
            bk_addr_r  <= kind_is_io(kind_s) ? {8'h00, bus.A[7:0]} : bus.A;
            bk_wdata_r <= bus.cpu_dout;
            kind_r     <= kind_s;
        end else if (ack_evt_s || timeout_evt_s) begin
            // A timed-out read returns the floating-bus value
            bk_req_r    <= 1'b0;
            cpu_di_en_r <= kind_is_read(kind_r);
            cpu_di_r    <= (ack_evt_s && kind_is_read(kind_r)) ? bus.bk_rdata : BUS_FLOAT;
        end else if (inta_enter_s) begin
            cpu_di_r    <= vec_s;
            cpu_di_en_r <= 1'b1;
            inta_had_r  <= pending_s;
        end else if (release_evt_s) begin
            cpu_di_r    <= BUS_FLOAT;
            cpu_di_en_r <= 1'b0;
            inta_had_r  <= 1'b0;
        end
    end

`ifdef Z80_BUS_RESPONDER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 32'sd1) > 32'sd8) ? $clog2(TIMEOUT + 32'sd1) : 32'sd8;

    logic [TO_W-1:0] to_cnt_r;
    logic            bus_err_r;

    // REQ dwell counter and one-cycle bus error strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r  <= {TO_W{1'b0}};
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= timeout_evt_s;
            if (state_r == ST_REQ) begin
                to_cnt_r <= to_cnt_r + {{(TO_W - 1){1'b0}}, 1'b1};
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

    assign to_hit_s    = (to_cnt_r == TO_W'(TIMEOUT - 32'sd1));
    assign bus.bus_err = bus_err_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT == 32'sd0);
    assign to_hit_s         = 1'b0;
    assign bus.bus_err      = 1'b0;
`endif

    z80_irq_ctrl u_irq_ctrl (
        .clk        (clk),
        .reset      (reset),
        .irq_req    (bus.irq_req),
        .irq_vector (bus.irq_vector),
        .clear      (inta_clr_s),
        .int_n      (int_n_s),
        .pending    (pending_s),
        .vector     (vec_s)
    );

    assign bus.wait_n    = wait_n_s;
    assign bus.int_n     = int_n_s;
    assign bus.bk_req    = bk_req_r;
    assign bus.bk_we     = bk_we_r;
    assign bus.bk_io     = bk_io_r;
    assign bus.bk_addr   = bk_addr_r;
    assign bus.bk_wdata  = bk_wdata_r;
    assign bus.cpu_di    = cpu_di_r;
    assign bus.cpu_di_en = cpu_di_en_r;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Self-checking bench for z80_bus_responder: vector table, randomized bus cycles against
// a window/latency model, plus refresh, interrupt, reset and timeout sequences.
module tb_z80_bus_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80_bus_responder_if bus();

    z80_bus_responder #(
        .MEM_BASE (16'h0000),
        .MEM_MASK (16'hC000),
        .IO_BASE  (8'h10),
        .IO_MASK  (8'hF0),
        .TIMEOUT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          delay;
        logic [7:0]  rdata;
        logic        exp_hit;
        logic [15:0] exp_addr;
        int          exp_wait;
        int          exp_req;
        logic [7:0]  exp_di;
        logic        exp_en;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_strobes();
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.rfsh_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".cpu_di"},    bus.cpu_di,    8'hFF);
        check({tag, ".cpu_di_en"}, bus.cpu_di_en, 1'b0);
        check({tag, ".wait_n"},    bus.wait_n,    1'b1);
        check({tag, ".int_n"},     bus.int_n,     1'b1);
        check({tag, ".bk_req"},    bus.bk_req,    1'b0);
        check({tag, ".bk_we"},     bus.bk_we,     1'b0);
        check({tag, ".bk_io"},     bus.bk_io,     1'b0);
        check({tag, ".bk_addr"},   bus.bk_addr,   16'h0000);
        check({tag, ".bk_wdata"},  bus.bk_wdata,  8'h00);
        check({tag, ".bus_err"},   bus.bus_err,   1'b0);
    endtask

    // Reference: memory window is 0x0000-0x3FFF, I/O window is ports 0x10-0x1F;
    // the backend acks on its delay-th request cycle, wait_n covers the strobe cycle too.
    function automatic vec_t model_vec(input logic io, input logic wr, input logic [15:0] addr,
                                       input logic [7:0] wdata, input int delay, input logic [7:0] rdata);
        vec_t v;
        v.io = io; v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay; v.rdata = rdata;
        if (io) begin
            v.exp_hit  = (addr[7:0] >= 8'h10) && (addr[7:0] <= 8'h1F);
            v.exp_addr = {8'h00, addr[7:0]};
        end else begin
            v.exp_hit  = (addr <= 16'h3FFF);
            v.exp_addr = addr;
        end
        v.exp_wait = v.exp_hit ? delay + 1 : 0;
        v.exp_req  = v.exp_hit ? delay : 0;
        v.exp_en   = v.exp_hit && !wr;
        v.exp_di   = rdata;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        int          wait_lo;
        int          req_hi;
        int          err_cnt;
        logic        acked;
        logic [15:0] c_addr;
        logic        c_we;
        logic        c_io;
        logic [7:0]  c_wdata;
        wait_lo = 0; req_hi = 0; err_cnt = 0; acked = 1'b0;
        c_addr = 16'h0000; c_we = 1'b0; c_io = 1'b0; c_wdata = 8'h00;
        @(posedge clk); #1;
        bus.A        = v.addr;
        bus.cpu_dout = v.wdata;
        if (v.io) bus.iorq_n = 1'b0; else bus.mreq_n = 1'b0;
        if (v.wr) bus.wr_n = 1'b0; else bus.rd_n = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!bus.wait_n) wait_lo++;
            if (bus.bus_err) err_cnt++;
            if (bus.bk_req) begin
                req_hi++;
                c_addr = bus.bk_addr; c_we = bus.bk_we; c_io = bus.bk_io; c_wdata = bus.bk_wdata;
                if (!acked && req_hi == v.delay) begin
                    bus.bk_ack   = 1'b1;
                    bus.bk_rdata = v.rdata;
                    acked        = 1'b1;
                end
            end
            @(posedge clk); #1;
            bus.bk_ack   = 1'b0;
            bus.bk_rdata = 8'h00;
        end
        @(negedge clk);
        check({tag, ".wait_cycles"}, wait_lo, v.exp_wait);
        check({tag, ".req_cycles"},  req_hi,  v.exp_req);
        check({tag, ".bus_err"},     err_cnt, 0);
        if (v.exp_hit) begin
            check({tag, ".bk_addr"}, c_addr, v.exp_addr);
            check({tag, ".bk_io"},   c_io,   v.io);
            check({tag, ".bk_we"},   c_we,   v.wr);
            if (v.wr) check({tag, ".bk_wdata"}, c_wdata, v.wdata);
        end
        check({tag, ".di_en"}, bus.cpu_di_en, v.exp_en);
        if (v.exp_en) check({tag, ".di"}, bus.cpu_di, v.exp_di);
        @(posedge clk); #1;
        idle_strobes();
        @(negedge clk);
        @(negedge clk);
        check({tag, ".di_en_after"}, bus.cpu_di_en, 1'b0);
    endtask

    task automatic do_inta(input logic [7:0] exp_vec, input logic edge_in_clear,
                           input logic exp_int_after, input string tag);
        @(posedge clk); #1;
        bus.m1_n   = 1'b0;
        bus.iorq_n = 1'b0;
        if (edge_in_clear) bus.irq_req = 1'b0;
        @(negedge clk);
        check({tag, ".wait_n0"}, bus.wait_n, 1'b1);
        @(negedge clk);
        check({tag, ".wait_n1"}, bus.wait_n, 1'b1);
        check({tag, ".di"},      bus.cpu_di, exp_vec);
        check({tag, ".di_en"},   bus.cpu_di_en, 1'b1);
        @(posedge clk); #1;
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        if (edge_in_clear) bus.irq_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, ".di_en_after"}, bus.cpu_di_en, 1'b0);
        check({tag, ".int_n_after"}, bus.int_n, exp_int_after);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.A          = 16'h0000;
        bus.cpu_dout   = 8'h00;
        bus.bk_ack     = 1'b0;
        bus.bk_rdata   = 8'h00;
        bus.irq_req    = 1'b0;
        bus.irq_vector = 8'h00;
        idle_strobes();

        //                io    wr    addr      wdata  dly rdata  hit   exp_addr  wait req di     en
        tbl[0] = '{1'b0, 1'b0, 16'h0123, 8'h00, 3, 8'h5A, 1'b1, 16'h0123, 4,   3,  8'h5A, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 16'h0012, 8'hC3, 1, 8'h00, 1'b1, 16'h0012, 2,   1,  8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0080, 8'h00, 2, 8'h11, 1'b0, 16'h0000, 0,   0,  8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h4000, 8'h00, 2, 8'h22, 1'b0, 16'h0000, 0,   0,  8'h00, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h3FFF, 8'h77, 2, 8'h00, 1'b1, 16'h3FFF, 3,   2,  8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hAB1F, 8'h00, 1, 8'h3C, 1'b1, 16'h001F, 2,   1,  8'h3C, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 16'h0020, 8'h44, 1, 8'h00, 1'b0, 16'h0000, 0,   0,  8'h00, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'hC000, 8'h00, 1, 8'h66, 1'b0, 16'h0000, 0,   0,  8'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 8; i++) begin
            apply_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Refresh with a read strobe and an in-window address must not start a cycle
        @(posedge clk); #1;
        bus.A = 16'h0040; bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; bus.rd_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rfsh%0d.bk_req", c), bus.bk_req, 1'b0);
            check($sformatf("rfsh%0d.wait_n", c), bus.wait_n, 1'b1);
        end
        @(posedge clk); #1;
        idle_strobes();
        @(negedge clk);
        check("rfsh.di_en", bus.cpu_di_en, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic        io;
            logic        wr;
            logic [15:0] addr;
            io = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                addr = io ? {8'($urandom), 4'h1, 4'($urandom)} : 16'($urandom_range(0, 16'h3FFF));
            end else begin
                addr = 16'($urandom);
            end
            apply_vec(model_vec(io, wr, addr, 8'($urandom), int'($urandom_range(1, 6)), 8'($urandom)),
                      $sformatf("rnd%0d", i));
        end

        // Interrupt: edge -> int_n low, IM2 vector, clear on iorq_n release
        @(posedge clk); #1;
        bus.irq_vector = 8'hE0;
        bus.irq_req    = 1'b1;
        @(negedge clk);
        check("irq.int_n_before", bus.int_n, 1'b1);
        @(negedge clk);
        check("irq.int_n_low", bus.int_n, 1'b0);
        do_inta(8'hE0, 1'b0, 1'b1, "inta1");

        @(posedge clk); #1 bus.irq_req = 1'b0;
        @(posedge clk); #1 bus.irq_req = 1'b1; bus.irq_vector = 8'h9C;
        @(negedge clk);
        @(negedge clk);
        check("irq2.int_n_low", bus.int_n, 1'b0);
        do_inta(8'h9C, 1'b1, 1'b0, "inta2");
        do_inta(8'h9C, 1'b0, 1'b1, "inta3");
        do_inta(8'hFF, 1'b0, 1'b1, "inta_none");

        // Reset while a request is outstanding; acks afterwards are dropped
        @(posedge clk); #1;
        bus.A = 16'h0200; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.bk_req_before", bus.bk_req, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        bus.bk_ack = 1'b1; bus.bk_rdata = 8'hA5;
        idle_strobes();
        @(negedge clk);
        check_reset_vals("rst.in");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst.bk_req_after", bus.bk_req, 1'b0);
        @(posedge clk); #1 bus.bk_ack = 1'b0;
        @(negedge clk);
        check("rst.di_en_after", bus.cpu_di_en, 1'b0);
        check("rst.di_after",    bus.cpu_di,    8'hFF);
        check("rst.wait_n",      bus.wait_n,    1'b1);
        apply_vec(model_vec(1'b0, 1'b0, 16'h0200, 8'h00, 2, 8'h81), "rst.next");

`ifdef Z80_BUS_RESPONDER_TIMEOUT_EN
        begin
            int wlo;
            int rhi;
            int ec;
            wlo = 0; rhi = 0; ec = 0;
            @(posedge clk); #1;
            bus.A = 16'h0010; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (!bus.wait_n) wlo++;
                if (bus.bk_req) rhi++;
                if (bus.bus_err) ec++;
            end
            check("to.req_cycles",  rhi, 8);
            check("to.wait_cycles", wlo, 9);
            check("to.bus_err",     ec,  1);
            check("to.di",          bus.cpu_di,    8'hFF);
            check("to.di_en",       bus.cpu_di_en, 1'b1);
            @(posedge clk); #1 bus.bk_ack = 1'b1; bus.bk_rdata = 8'h5A;
            @(posedge clk); #1 bus.bk_ack = 1'b0;
            @(negedge clk);
            check("to.late_di",     bus.cpu_di, 8'hFF);
            check("to.late_bk_req", bus.bk_req, 1'b0);
            @(posedge clk); #1 idle_strobes();
            @(negedge clk);
            @(negedge clk);
            check("to.di_en_after", bus.cpu_di_en, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
